// File: rtl/bitscan_if.sv
// Handshake bundle for bitscan_encoder.
// slave: encoder side; master: producer/consumer side.
interface bitscan_if #(
  parameter int NUM_WIRE = 8
);
  localparam int AW = $clog2(NUM_WIRE);
  localparam int CW = $clog2(NUM_WIRE + 1);

  logic [NUM_WIRE-1:0] d_i;
  logic                d_valid_i;
  logic                d_ready_o;
  logic [AW-1:0]       addr_o;
  logic                addr_valid_o;
  logic                addr_ready_i;
  logic                last_o;
  logic [CW-1:0]       count_o;

  modport slave (
    input  d_i,
    input  d_valid_i,
    output d_ready_o,
    output addr_o,
    output addr_valid_o,
    input  addr_ready_i,
    output last_o,
    output count_o
  );

  modport master (
    output d_i,
    output d_valid_i,
    input  d_ready_o,
    input  addr_o,
    input  addr_valid_o,
    output addr_ready_i,
    input  last_o,
    input  count_o
  );
endinterface

// File: rtl/bitscan_encoder.sv
// Multi-hot encoder: emits each set index of a captured vector,
// one per beat, with last/count. Ports: clk_i, rst_i (sync, high), bus.
module bitscan_encoder #(
  parameter int NUM_WIRE  = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic clk_i,
  input logic rst_i,
  bitscan_if.slave bus
);
  localparam int AW = $clog2(NUM_WIRE);
  localparam int CW = $clog2(NUM_WIRE + 1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t              state_q, state_d;
  logic [NUM_WIRE-1:0] pend_q, pend_d;
  logic [NUM_WIRE-1:0] sel_mask;
  logic [AW-1:0]       sel;
  logic [CW-1:0]       cnt;
  logic                emit;
  logic                last;
  logic                rdy;
  logic                in_acc;
  logic                out_acc;
  logic                d_nz;

  // Priority scan and popcount of the pending bits.
  always_comb begin
    sel = '0;
    cnt = '0;
    for (int i = 0; i < NUM_WIRE; i++) begin
      cnt = cnt + CW'(pend_q[i]);
    end
    if (MSB_FIRST) begin
      for (int i = 0; i < NUM_WIRE; i++) begin
        if (pend_q[i]) sel = AW'(i);
      end
    end else begin
      for (int i = NUM_WIRE - 1; i >= 0; i--) begin
        if (pend_q[i]) sel = AW'(i);
      end
    end
  end

  assign sel_mask = {{(NUM_WIRE-1){1'b0}}, 1'b1} << sel;

  assign emit = (state_q == EMIT);
  assign last = emit && (cnt == CW'(1));
  assign d_nz = |bus.d_i;

  // Ready during the final beat lets the next vector load with no bubble.
  assign rdy     = !rst_i && (!emit || (last && bus.addr_ready_i));
  assign in_acc  = bus.d_valid_i && rdy;
  assign out_acc = emit && bus.addr_ready_i;

  assign bus.d_ready_o    = rdy;
  assign bus.addr_valid_o = emit;
  assign bus.addr_o       = emit ? sel : '0;
  assign bus.count_o      = emit ? cnt : '0;
  assign bus.last_o       = last;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        if (in_acc && d_nz) begin
          pend_d  = bus.d_i;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_acc) begin
          if (!last) begin
            pend_d = pend_q & ~sel_mask;
          end else if (in_acc && d_nz) begin
            pend_d = bus.d_i;
          end else begin
            pend_d  = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        pend_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end
endmodule
